// File: rtl/mem_bridge.sv
// mem_bridge: freezes the core for each data-memory access and runs it as a
// single request/ack transaction on the bus. ram_en starts an access, and the
// core is released in DONE with the captured read data on ram_read_data.
//
// Optional feature: define MEM_BRIDGE_TIMEOUT_EN to bound the bus wait to
// TIMEOUT_CYCLES BUSY cycles. On expiry, a read returns ERR_DATA and the sticky
// bus_err flag is set. Without the macro, BUSY waits for bus_ack indefinitely
// and bus_err is tied low.
//
// state | meaning
// IDLE  | no access in flight; ram_en starts one
// BUSY  | bus_req held with latched address/mask/data, waiting for bus_ack
// DONE  | access finished, core released for one cycle, ram_en not sampled
module mem_bridge #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_en,
  input  logic [3:0]  ram_write_en,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_write_data,
  output logic [31:0] ram_read_data,
  output logic        stall,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  logic        req_q;
  logic [3:0]  we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  // The counter starts at 0 on BUSY entry. The last BUSY cycle is the one where
  // it reads TIMEOUT_CYCLES-1, so BUSY lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic        err_q;
  logic        timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);
  assign bus_err     = err_q;

  // BUSY cycle counter and sticky timeout flag; bus_ack always wins over expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && ram_en) begin
        cnt_q <= '0;
      end else if (state == BUSY && !bus_ack && !timeout_hit) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (state == BUSY && !bus_ack && timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT_CYCLES)};
  assign bus_err    = 1'b0;
`endif

  // Access sequencer: latch the core request, hold it on the bus until ack, then release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ram_en) begin
            state   <= BUSY;
            req_q   <= 1'b1;
            we_q    <= ram_write_en;
            addr_q  <= ram_addr;
            wdata_q <= ram_write_data;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state <= DONE;
            req_q <= 1'b0;
            we_q  <= 4'h0;
            if (we_q == 4'h0) begin
              rdata_q <= bus_rdata;
            end
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (timeout_hit) begin
            state <= DONE;
            req_q <= 1'b0;
            we_q  <= 4'h0;
            if (we_q == 4'h0) begin
              rdata_q <= ERR_DATA;
            end
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
          we_q  <= 4'h0;
        end
      endcase
    end
  end

  // The stall for a new request must reach the core in the same cycle as ram_en,
  // so it is decoded combinationally. It is gated by rst so reset forces it low.
  assign stall = rst & (req_q | ((state == IDLE) & ram_en));

  assign bus_req       = req_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign ram_read_data = rdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed scenarios for mem_bridge with hand-computed expectations.
// The timeout scenarios are compiled only when MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_mem_bridge;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int TC = 4;
`else
  localparam int TC = 256;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en = 1'b0;
  logic [3:0]  ram_write_en = 4'h0;
  logic [31:0] ram_addr = '0;
  logic [31:0] ram_write_data = '0;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_bridge #(.TIMEOUT_CYCLES(TC), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk            (clk),
    .rst            (rst),
    .ram_en         (ram_en),
    .ram_write_en   (ram_write_en),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .stall          (stall),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    ram_en = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #2;
    checks++; if ({stall, bus_req, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b exp 000", {stall, bus_req, bus_err}); end
    checks++; if (bus_we !== 4'h0) begin errors++; $display("FAIL reset_we: got %h exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", bus_wdata); end
    checks++; if (ram_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", ram_read_data); end
    ram_en = 1'b0; bus_ack = 1'b0; rst = 1'b1;
    tick();
    checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b exp 00", {stall, bus_req}); end
  endtask

  task automatic test_read();
    int stall_cnt = 0;
    int req_cnt = 0;
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h10000004; ram_write_data = 32'h0;
    #1;
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    checks++; if ({stall, bus_req} !== 2'b10) begin errors++; $display("FAIL read_detect: got %b exp 10", {stall, bus_req}); end
    tick();
    ram_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    #1;
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    checks++; if (bus_addr !== 32'h10000004) begin errors++; $display("FAIL read_addr: got %h exp 10000004", bus_addr); end
    checks++; if (bus_we !== 4'h0) begin errors++; $display("FAIL read_we: got %h exp 0", bus_we); end
    tick();
    bus_rdata = 32'hFFFF0000;
    #1;
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    checks++; if (ram_read_data !== 32'h12345678) begin errors++; $display("FAIL read_data_done: got %h exp 12345678", ram_read_data); end
    checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL read_done_ctrl: got %b exp 00", {stall, bus_req}); end
    tick();
    bus_ack = 1'b0;
    #1;
    if (stall) stall_cnt++;
    if (bus_req) req_cnt++;
    checks++; if (ram_read_data !== 32'h12345678) begin errors++; $display("FAIL read_ack_in_done: got %h exp 12345678", ram_read_data); end
    checks++; if (stall_cnt !== 2) begin errors++; $display("FAIL read_stall_cycles: got %0d exp 2", stall_cnt); end
    checks++; if (req_cnt !== 1) begin errors++; $display("FAIL read_req_cycles: got %0d exp 1", req_cnt); end
  endtask

  task automatic test_write();
    int stall_cnt = 0;
    int req_cnt = 0;
    int hold_cnt = 0;
    ram_en = 1'b1; ram_write_en = 4'b0011; ram_addr = 32'h80000010; ram_write_data = 32'hCAFEF00D;
    bus_rdata = 32'h55555555;
    #1;
    if (stall) stall_cnt++;
    tick();
    ram_en = 1'b0; ram_write_en = 4'h0; ram_addr = 32'h0; ram_write_data = 32'h0;
    for (int i = 1; i <= 5; i++) begin
      bus_ack = (i == 5);
      #1;
      if (stall) stall_cnt++;
      if (bus_req) req_cnt++;
      if (bus_req && bus_addr == 32'h80000010 && bus_we == 4'b0011 && bus_wdata == 32'hCAFEF00D) hold_cnt++;
      tick();
    end
    bus_ack = 1'b0;
    #1;
    if (stall) stall_cnt++;
    checks++; if (ram_read_data !== 32'h12345678) begin errors++; $display("FAIL write_rdata_kept: got %h exp 12345678", ram_read_data); end
    checks++; if ({stall, bus_req, bus_we} !== 6'b000000) begin errors++; $display("FAIL write_done_ctrl: got %b exp 000000", {stall, bus_req, bus_we}); end
    checks++; if (stall_cnt !== 6) begin errors++; $display("FAIL write_stall_cycles: got %0d exp 6", stall_cnt); end
    checks++; if (req_cnt !== 5) begin errors++; $display("FAIL write_req_cycles: got %0d exp 5", req_cnt); end
    checks++; if (hold_cnt !== 5) begin errors++; $display("FAIL write_hold_cycles: got %0d exp 5", hold_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_stall;
    logic [5:0] exp_req;
    logic       prev_req = 1'b0;
    int         req_edges = 0;
    exp_stall = 6'b011011;
    exp_req   = 6'b010010;
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h00000100;
    bus_ack = 1'b1; bus_rdata = 32'h11111111;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        ram_addr = 32'h00000200; bus_rdata = 32'h22222222;
      end
      #1;
      checks++; if ({stall, bus_req} !== {exp_stall[c], exp_req[c]}) begin errors++; $display("FAIL b2b_cycle%0d: got %b exp %b", c, {stall, bus_req}, {exp_stall[c], exp_req[c]}); end
      if (bus_req && !prev_req) req_edges++;
      prev_req = bus_req;
      if (c == 2) begin
        checks++; if (ram_read_data !== 32'h11111111) begin errors++; $display("FAIL b2b_first_data: got %h exp 11111111", ram_read_data); end
      end
      if (c == 4) begin
        checks++; if (bus_addr !== 32'h00000200) begin errors++; $display("FAIL b2b_second_addr: got %h exp 00000200", bus_addr); end
      end
      tick();
    end
    ram_en = 1'b0; bus_ack = 1'b0;
    #1;
    checks++; if (ram_read_data !== 32'h22222222) begin errors++; $display("FAIL b2b_second_data: got %h exp 22222222", ram_read_data); end
    checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got %b exp 00", {stall, bus_req}); end
    checks++; if (req_edges !== 2) begin errors++; $display("FAIL b2b_requests: got %0d exp 2", req_edges); end
    tick();
  endtask

  task automatic test_spurious_ack();
    ram_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL spur_ctrl%0d: got %b exp 00", i, {stall, bus_req}); end
      tick();
    end
    bus_ack = 1'b0;
    #1;
    checks++; if (ram_read_data !== 32'h22222222) begin errors++; $display("FAIL spur_rdata: got %h exp 22222222", ram_read_data); end
  endtask

  task automatic test_reset_busy();
    ram_en = 1'b1; ram_write_en = 4'hF; ram_addr = 32'h40000000; ram_write_data = 32'h00000001;
    #1;
    tick();
    tick();
    tick();
    #1;
    checks++; if ({stall, bus_req} !== 2'b11) begin errors++; $display("FAIL rstbusy_pre: got %b exp 11", {stall, bus_req}); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL rstbusy_async: got %b exp 00", {stall, bus_req}); end
    checks++; if (bus_we !== 4'h0) begin errors++; $display("FAIL rstbusy_we: got %h exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rstbusy_addr: got %h exp 0", bus_addr); end
    checks++; if (ram_read_data !== 32'h0) begin errors++; $display("FAIL rstbusy_rdata: got %h exp 0", ram_read_data); end
    #2;
    ram_en = 1'b0; rst = 1'b1;
    tick();
    checks++; if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL rstbusy_post: got %b exp 00", {stall, bus_req}); end
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h00000040;
    #1;
    tick();
    ram_en = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0F0F0F0F;
    #1;
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (ram_read_data !== 32'h0F0F0F0F) begin errors++; $display("FAIL rstbusy_recover: got %h exp 0F0F0F0F", ram_read_data); end
    tick();
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_ack_on_limit();
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h00000080;
    #1;
    tick();
    ram_en = 1'b0;
    repeat (3) tick();
    bus_ack = 1'b1; bus_rdata = 32'h13579BDF;
    #1;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL limit_req: got %b exp 1", bus_req); end
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (ram_read_data !== 32'h13579BDF) begin errors++; $display("FAIL limit_rdata: got %h exp 13579BDF", ram_read_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL limit_err: got %b exp 0", bus_err); end
    tick();
  endtask

  task automatic test_timeout();
    int busy_cnt = 0;
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h000000C0;
    #1;
    tick();
    ram_en = 1'b0;
    #1;
    while (bus_req && busy_cnt < 20) begin
      busy_cnt++;
      tick();
      #1;
    end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL timeout_cycles: got %0d exp 4", busy_cnt); end
    checks++; if (ram_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_rdata: got %h exp DEADBEEF", ram_read_data); end
    checks++; if ({bus_err, stall} !== 2'b10) begin errors++; $display("FAIL timeout_flags: got %b exp 10", {bus_err, stall}); end
    repeat (3) tick();
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b exp 1", bus_err); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b exp 0", bus_err); end
    rst = 1'b1;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    ram_en = 1'b1; ram_write_en = 4'h0; ram_addr = 32'h00000300;
    #1;
    tick();
    ram_en = 1'b0;
    repeat (300) tick();
    #1;
    checks++; if ({stall, bus_req, bus_err} !== 3'b110) begin errors++; $display("FAIL notimeout_wait: got %b exp 110", {stall, bus_req, bus_err}); end
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    #1;
    tick();
    bus_ack = 1'b0;
    #1;
    checks++; if (ram_read_data !== 32'h77777777) begin errors++; $display("FAIL notimeout_rdata: got %h exp 77777777", ram_read_data); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_spurious_ack();
    test_reset_busy();
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_ack_on_limit();
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, bus wait limit in cycles (range 2..65535).
- REQ-002 SHALL have parameter ERR_DATA, default 32'hDEADBEEF, read data returned on timeout.
- REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
- REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
- REQ-005 SHALL have port ram_en  in  1  core data-memory access request.
- REQ-006 SHALL have port ram_write_en  in  4  core byte-lane write mask; 0 means read.
- REQ-007 SHALL have port ram_addr  in  32  core access address.
- REQ-008 SHALL have port ram_write_data  in  32  core write data.
- REQ-009 SHALL have port ram_read_data  out  32  read data to core.
- REQ-010 SHALL have port stall  out  1  freeze request to the core pipeline.
- REQ-011 SHALL have port bus_req  out  1  bus request, held until ack.
- REQ-012 SHALL have port bus_we  out  4  latched byte-lane mask.
- REQ-013 SHALL have port bus_addr  out  32  latched address.
- REQ-014 SHALL have port bus_wdata  out  32  latched write data.
- REQ-015 SHALL have port bus_ack  in  1  bus completion strobe, one cycle.
- REQ-016 SHALL have port bus_rdata  in  32  bus read data, valid with bus_ack.
- REQ-017 SHALL have port bus_err  out  1  sticky timeout flag (timeout build only; tied 0 otherwise).

Function
- REQ-018 SHALL implement FSM states IDLE, BUSY, DONE; state register 2 bits.
- REQ-019 SHALL, in IDLE with ram_en=1, drive stall=1 combinationally, latch ram_addr/ram_write_en/ram_write_data at the edge, and go to BUSY.
- REQ-020 SHALL, in IDLE with ram_en=0, drive stall=0 and remain IDLE.
- REQ-021 SHALL, in BUSY, drive bus_req=1, stall=1, and bus_we/bus_addr/bus_wdata stable from the latched values.
- REQ-022 SHALL, in BUSY with bus_ack=1, capture bus_rdata into the read-data register (reads only; writes leave it unchanged) and go to DONE.
- REQ-023 SHALL, in DONE, drive stall=0, bus_req=0, ram_read_data = captured register, and return to IDLE unconditionally.
- REQ-024 SHALL drive ram_read_data from the captured register in all states.
- REQ-025 SHALL give minimum access latency of 3 cycles (IDLE-detect, BUSY with ack, DONE), i.e. 2 stall cycles.
- REQ-026 SHALL ignore bus_ack in IDLE and DONE.
- REQ-027 SHALL not issue a second bus request for the same access: ram_en in DONE is not re-sampled.
- REQ-028 SHALL drive bus_req=0 and bus_we=0 outside BUSY.

Reset
- REQ-029 SHALL on rst=0 immediately force state=IDLE, stall=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ram_read_data=0, bus_err=0, timeout counter=0.
- REQ-030 SHALL abort an in-flight access when reset asserts mid-BUSY; bus_req deasserts asynchronously.

Configuration
- REQ-031 SHALL, with MEM_BRIDGE_TIMEOUT_EN defined, count BUSY cycles; when count reaches TIMEOUT_CYCLES without ack, load ERR_DATA (reads), set bus_err, go to DONE.
- REQ-032 SHALL, with MEM_BRIDGE_TIMEOUT_EN defined, reset the counter on every IDLE->BUSY entry; ack on the limit cycle takes priority over timeout.
- REQ-033 SHALL, without MEM_BRIDGE_TIMEOUT_EN, wait in BUSY indefinitely and tie bus_err to 0 with no counter logic.

Verification
- REQ-034 Read, ack in first BUSY cycle, bus_rdata=32'h12345678 -> stall high 2 cycles, ram_read_data=32'h12345678 in DONE, one bus_req pulse of 1 cycle.
- REQ-035 Write ram_write_en=4'b0011, addr=32'h80000010, ack after 5 cycles -> bus_we=4'b0011, bus_addr held 5 cycles, stall high 6 cycles, ram_read_data unchanged.
- REQ-036 Back-to-back: ram_en held high across two accesses -> two separate requests, IDLE->BUSY->DONE->IDLE->BUSY, no duplicate request.
- REQ-037 rst=0 during BUSY (cycle 3 of wait) -> bus_req and stall drop without clock edge; post-reset ram_en=0 gives stall=0.
- REQ-038 Timeout build, TIMEOUT_CYCLES=4, no ack -> DONE after 4 BUSY cycles, ram_read_data=32'hDEADBEEF, bus_err=1 until reset.
- REQ-039 Spurious bus_ack in IDLE with ram_en=0 -> no state change, ram_read_data unchanged.
